// File: rtl/fft_mdc_stage_pkg.sv
// Shared definitions for the radix-2 MDC FFT stage.
// Contains the twiddle quantisation helpers (cos / -sin rounded to nearest
// on TW_FRAC fraction bits) and the signed saturation helper.
// Everything here is evaluated either at elaboration time (twiddles) or as
// plain combinational logic (saturation).
package fft_mdc_stage_pkg;

  localparam real MDC_PI = 3.14159265358979323846;

  // Round a real value to the nearest integer on 'frac' fraction bits,
  // ties away from zero.
  function automatic int tw_quant(input real x, input int frac);
    real scaled;
    scaled = x * $itor(32'sd1 <<< frac);
    if (scaled >= 0.0) begin
      return $rtoi($floor(scaled + 0.5));
    end else begin
      return -$rtoi($floor(-scaled + 0.5));
    end
  endfunction

  // Real part of W(k) = exp(-j*pi*k/delay).
  function automatic int tw_re(input int k, input int delay, input int frac);
    return tw_quant($cos(MDC_PI * $itor(k) / $itor(delay)), frac);
  endfunction

  // Imaginary part of W(k) = exp(-j*pi*k/delay).
  function automatic int tw_im(input int k, input int delay, input int frac);
    return tw_quant(-$sin(MDC_PI * $itor(k) / $itor(delay)), frac);
  endfunction

  // Clamp a signed value to the range of a w-bit two's complement number.
  function automatic longint sat(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (w - 32'sd1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 32'sd1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/fft_mdc_stage_delay_line.sv
// mdc_delay_line: complex shift register of DEPTH stages.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset (clears stages)
//   en                - shift enable; when low every stage holds
//   in_re, in_im      - sample entering stage 0
//   out_re, out_im    - sample leaving the last stage (DEPTH enables later)
module mdc_delay_line #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im
);

  logic [WIDTH-1:0] re_r [DEPTH];
  logic [WIDTH-1:0] im_r [DEPTH];

  // Shift register: stage 0 takes the input, each later stage its predecessor
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        re_r[i] <= '0;
        im_r[i] <= '0;
      end
    end else if (en) begin
      re_r[0] <= in_re;
      im_r[0] <= in_im;
      for (int i = 1; i < DEPTH; i++) begin
        re_r[i] <= re_r[i-1];
        im_r[i] <= im_r[i-1];
      end
    end
  end

  assign out_re = re_r[DEPTH-1];
  assign out_im = im_r[DEPTH-1];

endmodule

// File: rtl/fft_mdc_stage.sv
// fft_mdc_stage: one radix-2 multi-path delay commutator FFT stage.
// The lower rail is delayed by DELAY samples, a commutator (driven by the
// MSB of the sample counter) swaps the delayed-lower and upper paths, the
// commutator-upper path is delayed by another DELAY samples and a butterfly
// combines it with the commutator-lower path. The difference is rotated by
// W(k) = exp(-j*pi*k/DELAY). Outputs are registered, one cycle after the
// accepted input, once 2*DELAY samples have filled the pipeline.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   clear                          - synchronous frame restart (beats in_valid)
//   in_valid                       - input pair valid; low cycles freeze state
//   in_up_re/im, in_l_re/im        - upper / lower input rails (signed)
//   out_valid                      - registered output pair valid
//   out_up_re/im, out_l_re/im      - registered sum / rotated difference
module fft_mdc_stage
  import fft_mdc_stage_pkg::*;
#(
  parameter int WIDTH    = 9,
  parameter int DELAY    = 2,
  parameter int TW_FRAC  = 7,
  parameter int SCALE_EN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_up_re,
  input  logic [WIDTH-1:0] in_up_im,
  input  logic [WIDTH-1:0] in_l_re,
  input  logic [WIDTH-1:0] in_l_im,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_up_re,
  output logic [WIDTH-1:0] out_up_im,
  output logic [WIDTH-1:0] out_l_re,
  output logic [WIDTH-1:0] out_l_im
);

  localparam int KW  = $clog2(DELAY);
  localparam int CW  = KW + 1;
  localparam int FW  = KW + 2;
  localparam int TWW = TW_FRAC + 2;

  logic [CW-1:0] cnt_r;
  logic [FW-1:0] fill_r;
  logic          accept_s;
  logic          primed_s;
  logic          load_s;
  logic          sel_s;
  logic [KW-1:0] k_s;

  logic signed [WIDTH-1:0] dl_re_s, dl_im_s;
  logic signed [WIDTH-1:0] cu_re_s, cu_im_s;
  logic signed [WIDTH-1:0] b_re_s, b_im_s;
  logic signed [WIDTH-1:0] a_re_s, a_im_s;

  logic signed [WIDTH:0]   sum_re_s, sum_im_s, dif_re_s, dif_im_s;
  logic signed [WIDTH:0]   sum_re_sc_s, sum_im_sc_s, dif_re_sc_s, dif_im_sc_s;
  logic signed [WIDTH-1:0] up_re_s, up_im_s, dsat_re_s, dsat_im_s;
  logic signed [WIDTH-1:0] l_re_s, l_im_s;
  logic signed [TWW-1:0]   w_re_s, w_im_s;
  longint                  prod_re_s, prod_im_s;

  logic signed [TWW-1:0] tw_re_tab [DELAY];
  logic signed [TWW-1:0] tw_im_tab [DELAY];

  // A clear in the same cycle discards the sample, so it must not shift anything.
  assign accept_s = in_valid & ~clear;
  assign primed_s = (fill_r == FW'(2 * DELAY));
  assign load_s   = accept_s & primed_s;
  assign sel_s    = cnt_r[CW-1];
  assign k_s      = cnt_r[KW-1:0];

  // Twiddle constants, one per k, computed at elaboration.
  for (genvar gi = 0; gi < DELAY; gi++) begin : g_tw
    localparam int TR = tw_re(gi, DELAY, TW_FRAC);
    localparam int TI = tw_im(gi, DELAY, TW_FRAC);
    assign tw_re_tab[gi] = TWW'(TR);
    assign tw_im_tab[gi] = TWW'(TI);
  end

  // Sample counter; width makes the wrap from 2*DELAY-1 to 0 implicit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (in_valid) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  // Fill counter; saturates at 2*DELAY to mark the pipeline as primed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_r <= '0;
    end else if (clear) begin
      fill_r <= '0;
    end else if (in_valid && !primed_s) begin
      fill_r <= fill_r + FW'(1'b1);
    end
  end

  mdc_delay_line #(.WIDTH(WIDTH), .DEPTH(DELAY)) u_dl_low (
    .clk    (clk),
    .rst    (rst),
    .en     (accept_s),
    .in_re  (in_l_re),
    .in_im  (in_l_im),
    .out_re (dl_re_s),
    .out_im (dl_im_s)
  );

  // Commutator: straight when sel is 0, swapped when sel is 1
  always_comb begin
    if (sel_s) begin
      cu_re_s = dl_re_s;
      cu_im_s = dl_im_s;
      b_re_s  = $signed(in_up_re);
      b_im_s  = $signed(in_up_im);
    end else begin
      cu_re_s = $signed(in_up_re);
      cu_im_s = $signed(in_up_im);
      b_re_s  = dl_re_s;
      b_im_s  = dl_im_s;
    end
  end

  mdc_delay_line #(.WIDTH(WIDTH), .DEPTH(DELAY)) u_dl_up (
    .clk    (clk),
    .rst    (rst),
    .en     (accept_s),
    .in_re  (cu_re_s),
    .in_im  (cu_im_s),
    .out_re (a_re_s),
    .out_im (a_im_s)
  );

  // Butterfly at WIDTH+1 bits, optional halving, saturation, twiddle rotation
  always_comb begin
    sum_re_s = {a_re_s[WIDTH-1], a_re_s} + {b_re_s[WIDTH-1], b_re_s};
    sum_im_s = {a_im_s[WIDTH-1], a_im_s} + {b_im_s[WIDTH-1], b_im_s};
    dif_re_s = {a_re_s[WIDTH-1], a_re_s} - {b_re_s[WIDTH-1], b_re_s};
    dif_im_s = {a_im_s[WIDTH-1], a_im_s} - {b_im_s[WIDTH-1], b_im_s};
    if (SCALE_EN != 0) begin
      sum_re_sc_s = sum_re_s >>> 32'd1;
      sum_im_sc_s = sum_im_s >>> 32'd1;
      dif_re_sc_s = dif_re_s >>> 32'd1;
      dif_im_sc_s = dif_im_s >>> 32'd1;
    end else begin
      sum_re_sc_s = sum_re_s;
      sum_im_sc_s = sum_im_s;
      dif_re_sc_s = dif_re_s;
      dif_im_sc_s = dif_im_s;
    end
    up_re_s   = WIDTH'(sat(longint'(sum_re_sc_s), WIDTH));
    up_im_s   = WIDTH'(sat(longint'(sum_im_sc_s), WIDTH));
    dsat_re_s = WIDTH'(sat(longint'(dif_re_sc_s), WIDTH));
    dsat_im_s = WIDTH'(sat(longint'(dif_im_sc_s), WIDTH));
    w_re_s    = tw_re_tab[k_s];
    w_im_s    = tw_im_tab[k_s];
    // Full-precision complex product; >>> on a signed value floors.
    prod_re_s = longint'(dsat_re_s) * longint'(w_re_s) - longint'(dsat_im_s) * longint'(w_im_s);
    prod_im_s = longint'(dsat_re_s) * longint'(w_im_s) + longint'(dsat_im_s) * longint'(w_re_s);
    l_re_s    = WIDTH'(sat(prod_re_s >>> TW_FRAC, WIDTH));
    l_im_s    = WIDTH'(sat(prod_im_s >>> TW_FRAC, WIDTH));
  end

  // Output registers: valid follows load by one cycle, data loads only with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_up_re <= '0;
      out_up_im <= '0;
      out_l_re  <= '0;
      out_l_im  <= '0;
    end else begin
      out_valid <= load_s;
      if (load_s) begin
        out_up_re <= up_re_s;
        out_up_im <= up_im_s;
        out_l_re  <= l_re_s;
        out_l_im  <= l_im_s;
      end
    end
  end

endmodule

// File: tb/tb_fft_mdc_stage.sv
// Self-checking bench for fft_mdc_stage (WIDTH=9, DELAY=2, TW_FRAC=7).
// Two instances share the stimulus: dut0 with SCALE_EN=0, dut1 with SCALE_EN=1.
module tb_fft_mdc_stage;

  localparam int W = 9;
  localparam int D = 2;
  localparam int F = 7;

  logic clk, rst, clear, in_valid;
  logic [W-1:0] in_up_re, in_up_im, in_l_re, in_l_im;
  logic o0_valid, o1_valid;
  logic [W-1:0] o0_up_re, o0_up_im, o0_l_re, o0_l_im;
  logic [W-1:0] o1_up_re, o1_up_im, o1_l_re, o1_l_im;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ur0, ui0, lr0, li0, ur1, ui1, lr1, li1;
  } exp_t;

  typedef struct {
    int ur, ui, lr, li;
  } cap_t;

  typedef struct {
    int ar, ai, br, bi, k;
    int ur0, ui0, lr0, li0;
    int ur1, ui1, lr1, li1;
  } vec_t;

  // accepted samples since the last reset/clear, indexed by sample number
  int hu_re[$], hu_im[$], hl_re[$], hl_im[$];
  exp_t expq[$];
  cap_t cap[$];
  cap_t capa[$];
  bit   cap_en = 1'b0;

  fft_mdc_stage #(.WIDTH(W), .DELAY(D), .TW_FRAC(F), .SCALE_EN(0)) dut0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_up_re(in_up_re), .in_up_im(in_up_im), .in_l_re(in_l_re), .in_l_im(in_l_im),
    .out_valid(o0_valid), .out_up_re(o0_up_re), .out_up_im(o0_up_im),
    .out_l_re(o0_l_re), .out_l_im(o0_l_im)
  );

  fft_mdc_stage #(.WIDTH(W), .DELAY(D), .TW_FRAC(F), .SCALE_EN(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_up_re(in_up_re), .in_up_im(in_up_im), .in_l_re(in_l_re), .in_l_im(in_l_im),
    .out_valid(o1_valid), .out_up_re(o1_up_re), .out_up_im(o1_up_im),
    .out_l_re(o1_l_re), .out_l_im(o1_l_im)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endfunction

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int bsat(input int v);
    int hi, lo;
    hi = (1 << (W - 1)) - 1;
    lo = -(1 << (W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // twiddle W(k) = exp(-j*pi*k/D), rounded to nearest on F fraction bits
  function automatic int twr(input int k);
    return $rtoi($floor($cos(3.14159265358979 * k / D) * (1 << F) + 0.5));
  endfunction

  function automatic int twi(input int k);
    return $rtoi($floor(-$sin(3.14159265358979 * k / D) * (1 << F) + 0.5));
  endfunction

  function automatic void bfly(input int ar, ai, br, bi, k, sc,
                               output int ur, ui, lr, li);
    int sr, si, dr, di, wr, wi;
    sr = ar + br; si = ai + bi; dr = ar - br; di = ai - bi;
    if (sc != 0) begin
      sr = sr >>> 1; si = si >>> 1; dr = dr >>> 1; di = di >>> 1;
    end
    ur = bsat(sr); ui = bsat(si); dr = bsat(dr); di = bsat(di);
    wr = twr(k); wi = twi(k);
    lr = bsat((dr * wr - di * wi) >>> F);
    li = bsat((dr * wi + di * wr) >>> F);
  endfunction

  // Commutator outputs for sample m: lower rail seen D samples late,
  // swapped with the upper rail in the second half of each 2*D period.
  function automatic void comm(input int m, output int cur, cui, clr_, cli);
    if ((m % (2 * D)) >= D) begin
      cur = hl_re[m - D]; cui = hl_im[m - D]; clr_ = hu_re[m]; cli = hu_im[m];
    end else begin
      cur = hu_re[m]; cui = hu_im[m]; clr_ = hl_re[m - D]; cli = hl_im[m - D];
    end
  endfunction

  function automatic exp_t model_out(input int n);
    exp_t e;
    int ar, ai, br, bi, x0, x1, ur, ui, lr, li;
    comm(n - D, ar, ai, x0, x1);
    comm(n, x0, x1, br, bi);
    bfly(ar, ai, br, bi, n % D, 0, ur, ui, lr, li);
    e.ur0 = ur; e.ui0 = ui; e.lr0 = lr; e.li0 = li;
    bfly(ar, ai, br, bi, n % D, 1, ur, ui, lr, li);
    e.ur1 = ur; e.ui1 = ui; e.lr1 = lr; e.li1 = li;
    return e;
  endfunction

  // Reference model: records accepted samples and predicts each output
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        hu_re.delete(); hu_im.delete(); hl_re.delete(); hl_im.delete();
        expq.delete();
      end else if (clear) begin
        hu_re.delete(); hu_im.delete(); hl_re.delete(); hl_im.delete();
      end else if (in_valid) begin
        hu_re.push_back(sx(in_up_re)); hu_im.push_back(sx(in_up_im));
        hl_re.push_back(sx(in_l_re));  hl_im.push_back(sx(in_l_im));
        if (hu_re.size() > 2 * D) expq.push_back(model_out(hu_re.size() - 1));
      end
    end
  end

  // Scoreboard: compares both instances with the model on every falling edge
  initial begin
    exp_t e;
    cap_t c;
    forever begin
      @(negedge clk);
      chk("sb_valid0", int'(o0_valid), int'(expq.size() > 0));
      chk("sb_valid1", int'(o1_valid), int'(expq.size() > 0));
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("sb_up_re0", sx(o0_up_re), e.ur0); chk("sb_up_im0", sx(o0_up_im), e.ui0);
        chk("sb_l_re0",  sx(o0_l_re),  e.lr0); chk("sb_l_im0",  sx(o0_l_im),  e.li0);
        chk("sb_up_re1", sx(o1_up_re), e.ur1); chk("sb_up_im1", sx(o1_up_im), e.ui1);
        chk("sb_l_re1",  sx(o1_l_re),  e.lr1); chk("sb_l_im1",  sx(o1_l_im),  e.li1);
      end
      if (cap_en && o0_valid) begin
        c.ur = sx(o0_up_re); c.ui = sx(o0_up_im); c.lr = sx(o0_l_re); c.li = sx(o0_l_im);
        cap.push_back(c);
      end
    end
  end

  function automatic int rnd();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  task automatic step(input bit v, input int ur, ui, lr, li, input bit c);
    logic [31:0] t0, t1, t2, t3;
    t0 = ur; t1 = ui; t2 = lr; t3 = li;
    in_valid = v; clear = c;
    in_up_re = t0[W-1:0]; in_up_im = t1[W-1:0];
    in_l_re  = t2[W-1:0]; in_l_im  = t3[W-1:0];
    @(posedge clk);
    #1;
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic do_clear();
    step(1'b0, 0, 0, 0, 0, 1'b1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid0"}, int'(o0_valid), 0);
    chk({tag, "_valid1"}, int'(o1_valid), 0);
    chk({tag, "_data0"}, int'(|{o0_up_re, o0_up_im, o0_l_re, o0_l_im}), 0);
    chk({tag, "_data1"}, int'(|{o1_up_re, o1_up_im, o1_l_re, o1_l_im}), 0);
  endtask

  vec_t vt[9];
  int sr[16][4];

  initial begin
    // butterfly operands a (delayed commutator-upper), b, k and expected outputs
    vt[0] = '{10, 0, 10, 0, 0,      20, 0, 0, 0,        10, 0, 0, 0};
    vt[1] = '{64, 0, 0, 0, 1,       64, 0, 0, -64,      32, 0, 0, -32};
    vt[2] = '{255, 0, 255, 0, 0,    255, 0, 0, 0,       255, 0, 0, 0};
    vt[3] = '{-256, 0, -256, 0, 0,  -256, 0, 0, 0,      -256, 0, 0, 0};
    vt[4] = '{255, 0, -256, 0, 0,   -1, 0, 255, 0,      -1, 0, 255, 0};
    vt[5] = '{3, 5, 1, -2, 1,       4, 3, 7, -2,        2, 1, 3, -1};
    vt[6] = '{-100, 50, -200, -30, 1, -256, 20, 80, -100, -150, 10, 40, -50};
    vt[7] = '{0, -256, 0, 255, 1,   0, -1, -256, 0,     0, -1, -256, 0};
    vt[8] = '{-256, 0, 0, 0, 1,     -256, 0, 0, 255,    -128, 0, 0, 128};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
    in_up_re = '0; in_up_im = '0; in_l_re = '0; in_l_im = '0;
    #2;
    chk_zero_outputs("reset_state");
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed butterfly table. With D=2, sample n=4+k sees a = L[k], b = L[k+2].
    for (int r = 0; r < 9; r++) begin
      do_clear();
      for (int n = 0; n < 6; n++) begin
        if (n == vt[r].k) step(1'b1, 0, 0, vt[r].ar, vt[r].ai, 1'b0);
        else if (n == vt[r].k + 2) step(1'b1, 0, 0, vt[r].br, vt[r].bi, 1'b0);
        else step(1'b1, 0, 0, 0, 0, 1'b0);
        if (n == 4 + vt[r].k) begin
          chk($sformatf("vec%0d_valid", r), int'(o0_valid), 1);
          chk($sformatf("vec%0d_up_re0", r), sx(o0_up_re), vt[r].ur0);
          chk($sformatf("vec%0d_up_im0", r), sx(o0_up_im), vt[r].ui0);
          chk($sformatf("vec%0d_l_re0", r),  sx(o0_l_re),  vt[r].lr0);
          chk($sformatf("vec%0d_l_im0", r),  sx(o0_l_im),  vt[r].li0);
          chk($sformatf("vec%0d_up_re1", r), sx(o1_up_re), vt[r].ur1);
          chk($sformatf("vec%0d_up_im1", r), sx(o1_up_im), vt[r].ui1);
          chk($sformatf("vec%0d_l_re1", r),  sx(o1_l_re),  vt[r].lr1);
          chk($sformatf("vec%0d_l_im1", r),  sx(o1_l_im),  vt[r].li1);
        end
      end
    end

    // Constant input 10+0j on all rails
    do_clear();
    for (int n = 0; n < 8; n++) begin
      step(1'b1, 10, 0, 10, 0, 1'b0);
      chk("const_valid", int'(o0_valid), int'(n >= 4));
      if (n >= 4) begin
        chk("const_up_re", sx(o0_up_re), 20);
        chk("const_up_im", sx(o0_up_im), 0);
        chk("const_l_re", sx(o0_l_re), 0);
        chk("const_l_im", sx(o0_l_im), 0);
      end
    end

    // Reset mid-stream: outputs drop in the same cycle, then re-prime
    do_clear();
    for (int n = 0; n < 6; n++) step(1'b1, rnd(), rnd(), rnd(), rnd(), 1'b0);
    chk("pre_reset_valid", int'(o0_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk_zero_outputs("async_reset");
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int n = 0; n < 5; n++) begin
      step(1'b1, rnd(), rnd(), rnd(), rnd(), 1'b0);
      chk("post_reset_valid", int'(o0_valid), int'(n == 4));
    end

    // Clear together with in_valid at cnt=3: sample dropped, cnt back to 0
    do_clear();
    for (int n = 0; n < 7; n++) step(1'b1, rnd(), rnd(), rnd(), rnd(), 1'b0);
    step(1'b1, rnd(), rnd(), rnd(), rnd(), 1'b1);
    chk("clear_cnt", int'(dut0.cnt_r), 0);
    chk("clear_valid", int'(o0_valid), 0);
    for (int n = 0; n < 5; n++) begin
      step(1'b1, rnd(), rnd(), rnd(), rnd(), 1'b0);
      chk("post_clear_valid", int'(o0_valid), int'(n == 4));
    end

    // Stall: same 16 pairs gapless and with 1,0,1,0 valid pattern
    for (int i = 0; i < 16; i++) for (int j = 0; j < 4; j++) sr[i][j] = rnd();
    do_clear();
    cap.delete();
    cap_en = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, sr[i][0], sr[i][1], sr[i][2], sr[i][3], 1'b0);
    step(1'b0, 0, 0, 0, 0, 1'b0);
    cap_en = 1'b0;
    capa = cap;
    cap.delete();
    do_clear();
    cap_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, sr[i][0], sr[i][1], sr[i][2], sr[i][3], 1'b0);
      step(1'b0, rnd(), rnd(), rnd(), rnd(), 1'b0);
    end
    step(1'b0, 0, 0, 0, 0, 1'b0);
    cap_en = 1'b0;
    chk("stall_count_gapless", capa.size(), 12);
    chk("stall_count_gapped", cap.size(), 12);
    if (capa.size() == 12 && cap.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        chk($sformatf("stall_up_re%0d", i), cap[i].ur, capa[i].ur);
        chk($sformatf("stall_up_im%0d", i), cap[i].ui, capa[i].ui);
        chk($sformatf("stall_l_re%0d", i), cap[i].lr, capa[i].lr);
        chk($sformatf("stall_l_im%0d", i), cap[i].li, capa[i].li);
      end
    end

    // Random traffic with stalls and occasional clears, checked by the scoreboard
    do_clear();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), rnd(), rnd(), rnd(), rnd(),
           ($urandom_range(0, 40) == 0));
    end
    step(1'b0, 0, 0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
